// File: rtl/conv_acc_pkg.sv
// Shared types and width/limit helpers for the convolution output accumulator.
package conv_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FINAL,
        ST_FLUSH
    } conv_acc_state_e;

    // Accumulator width: full convolver product width plus growth for the channel sum.
    function automatic int acc_width(input int n, input int max_channels);
        return 2 * n + $clog2(max_channels);
    endfunction

    function automatic longint sat_max(input int n);
        return (longint'(1) <<< (n - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int n);
        return -(longint'(1) <<< (n - 1));
    endfunction

endpackage

// File: rtl/conv_requant.sv
// One lane of round-half-up arithmetic shift, saturation to N bits and optional ReLU.
// ReLU logic exists only when CONV_ACC_RELU_EN is defined.
module conv_requant
    import conv_acc_pkg::*;
#(
    parameter int N     = 16,
    parameter int ACC_W = 40,
    parameter int SH_W  = $clog2(ACC_W)
) (
    input  logic signed [ACC_W-1:0] sum,
    input  logic [SH_W-1:0]         shift,
    input  logic                    relu_en,
    output logic [N-1:0]            q,
    output logic                    sat
);

    localparam logic signed [ACC_W:0] SAT_HI = (ACC_W + 1)'(sat_max(N));
    localparam logic signed [ACC_W:0] SAT_LO = (ACC_W + 1)'(sat_min(N));

    // One guard bit so the rounding bias can never wrap the sum.
    logic signed [ACC_W:0] sum_ext;
    logic signed [ACC_W:0] bias;
    logic signed [ACC_W:0] biased;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        sum_ext = {sum[ACC_W-1], sum};
        bias    = '0;
        if (shift != '0) begin
            bias[shift - SH_W'(1)] = 1'b1;
        end
        biased  = sum_ext + bias;
        shifted = biased >>> shift;
        sat     = 1'b0;
        q       = shifted[N-1:0];
        if (shifted > SAT_HI) begin
            q   = SAT_HI[N-1:0];
            sat = 1'b1;
        end else if (shifted < SAT_LO) begin
            q   = SAT_LO[N-1:0];
            sat = 1'b1;
        end
`ifdef CONV_ACC_RELU_EN
        if (relu_en && q[N-1]) begin
            q = '0;
        end
`endif
    end

`ifndef CONV_ACC_RELU_EN
    logic relu_unused;
    assign relu_unused = relu_en;
`endif

endmodule

// File: rtl/conv_accumulator.sv
// Multi-lane channel accumulator with requantised valid/ready output stage.
// Define CONV_ACC_RELU_EN to build the optional ReLU.
module conv_accumulator
    import conv_acc_pkg::*;
#(
    parameter int  LANES        = 4,
    parameter int  N            = 16,
    parameter int  DEPTH        = 1024,
    parameter int  MAX_CHANNELS = 256,
    localparam int ACC_W        = acc_width(N, MAX_CHANNELS),
    localparam int CH_W         = $clog2(MAX_CHANNELS + 1),
    localparam int POS_W        = $clog2(DEPTH + 1),
    localparam int SH_W         = $clog2(ACC_W)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [CH_W-1:0]           channels_i,
    input  logic [POS_W-1:0]          positions_i,
    input  logic [SH_W-1:0]           shift_i,
    input  logic                      relu_en_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [LANES-1:0][2*N-1:0] in_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES-1:0][N-1:0]   out_data_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overflow_o
);

    localparam int IDX_W = $clog2(DEPTH);

    conv_acc_state_e          state_reg;
    logic [POS_W-1:0]         pos_reg;
    logic [POS_W-1:0]         positions_reg;
    logic [CH_W-1:0]          ch_reg;
    logic [CH_W-1:0]          channels_reg;
    logic [SH_W-1:0]          shift_reg;
    logic                     out_valid_reg;
    logic                     done_reg;
    logic                     overflow_reg;
    logic [LANES-1:0][N-1:0]  out_data_reg;

    logic [LANES-1:0][N-1:0]  q_lane;
    logic [LANES-1:0]         sat_lane;
    logic                     in_ready;
    logic                     acc_we;
    logic                     fin_fire;
    logic                     last_pos;
    logic                     relu_eff;
    logic [CH_W-1:0]          channels_eff;
    logic [SH_W-1:0]          shift_eff;

    assign channels_eff = (channels_i == '0) ? CH_W'(1) : channels_i;
    assign shift_eff    = (int'(shift_i) >= ACC_W) ? SH_W'(ACC_W - 1) : shift_i;
    assign last_pos     = (pos_reg == positions_reg - POS_W'(1));

    // FINAL acts as a single-entry skid: accept only if the output slot frees this cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state_reg)
            ST_ACCUM: in_ready = 1'b1;
            ST_FINAL: in_ready = !out_valid_reg || out_ready_i;
            default:  in_ready = 1'b0;
        endcase
    end

    assign acc_we   = (state_reg == ST_ACCUM) && in_valid_i;
    assign fin_fire = (state_reg == ST_FINAL) && in_valid_i && in_ready;

`ifdef CONV_ACC_RELU_EN
    logic relu_reg;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            relu_reg <= 1'b0;
        end else if (state_reg == ST_IDLE && start_i) begin
            relu_reg <= relu_en_i;
        end
    end
    assign relu_eff = relu_reg;
`else
    logic relu_unused;
    assign relu_unused = relu_en_i;
    assign relu_eff    = 1'b0;
`endif

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACC_W-1:0]        mem [DEPTH];
            logic signed [ACC_W-1:0] in_ext;
            logic signed [ACC_W-1:0] psum;
            logic signed [ACC_W-1:0] fin_sum;

            assign in_ext  = {{(ACC_W - 2*N){in_data_i[gi][2*N-1]}}, in_data_i[gi]};
            assign psum    = mem[pos_reg[IDX_W-1:0]];
            assign fin_sum = (channels_reg == CH_W'(1)) ? in_ext : psum + in_ext;

            // Partial sums are never reset; channel 0 overwrites whatever is stored.
            always_ff @(posedge clk_i) begin
                if (acc_we) begin
                    mem[pos_reg[IDX_W-1:0]] <= (ch_reg == '0) ? in_ext : psum + in_ext;
                end
            end

            conv_requant #(
                .N     (N),
                .ACC_W (ACC_W),
                .SH_W  (SH_W)
            ) u_requant (
                .sum     (fin_sum),
                .shift   (shift_reg),
                .relu_en (relu_eff),
                .q       (q_lane[gi]),
                .sat     (sat_lane[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= ST_IDLE;
            pos_reg       <= '0;
            positions_reg <= '0;
            ch_reg        <= '0;
            channels_reg  <= '0;
            shift_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            done_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (start_i) begin
                        channels_reg  <= channels_eff;
                        positions_reg <= positions_i;
                        shift_reg     <= shift_eff;
                        pos_reg       <= '0;
                        ch_reg        <= '0;
                        overflow_reg  <= 1'b0;
                        if (positions_i == '0) begin
                            done_reg <= 1'b1;
                        end else if (channels_eff == CH_W'(1)) begin
                            state_reg <= ST_FINAL;
                        end else begin
                            state_reg <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid_i) begin
                        if (last_pos) begin
                            pos_reg <= '0;
                            ch_reg  <= ch_reg + CH_W'(1);
                            if (ch_reg == channels_reg - CH_W'(2)) begin
                                state_reg <= ST_FINAL;
                            end
                        end else begin
                            pos_reg <= pos_reg + POS_W'(1);
                        end
                    end
                end
                ST_FINAL: begin
                    if (fin_fire) begin
                        out_data_reg  <= q_lane;
                        out_valid_reg <= 1'b1;
                        overflow_reg  <= overflow_reg | (|sat_lane);
                        if (last_pos) begin
                            pos_reg   <= '0;
                            state_reg <= ST_FLUSH;
                        end else begin
                            pos_reg <= pos_reg + POS_W'(1);
                        end
                    end else if (out_ready_i) begin
                        out_valid_reg <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    if (!out_valid_reg || out_ready_i) begin
                        out_valid_reg <= 1'b0;
                        done_reg      <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign busy_o      = (state_reg != ST_IDLE);
    assign done_o      = done_reg;
    assign overflow_o  = overflow_reg;

endmodule

// File: tb/tb_conv_accumulator.sv
// Randomised self-checking bench for conv_accumulator against an arithmetic reference model.
module tb_conv_accumulator;

    localparam int LANES = 2;
    localparam int N     = 16;
    localparam int DEPTH = 16;
    localparam int MAXCH = 256;
    localparam int CH_W  = $clog2(MAXCH + 1);
    localparam int POS_W = $clog2(DEPTH + 1);
    localparam int SH_W  = 6;

    typedef logic [LANES-1:0][N-1:0] out_t;

    logic                      clk_i = 1'b0;
    logic                      rst_i = 1'b0;
    logic                      start_i = 1'b0;
    logic [CH_W-1:0]           channels_i = '0;
    logic [POS_W-1:0]          positions_i = '0;
    logic [SH_W-1:0]           shift_i = '0;
    logic                      relu_en_i = 1'b0;
    logic                      in_valid_i = 1'b0;
    logic                      in_ready_o;
    logic [LANES-1:0][2*N-1:0] in_data_i = '0;
    logic                      out_valid_o;
    logic                      out_ready_i = 1'b0;
    out_t                      out_data_o;
    logic                      busy_o;
    logic                      done_o;
    logic                      overflow_o;

    always #5 clk_i = ~clk_i;

    conv_accumulator #(
        .LANES        (LANES),
        .N            (N),
        .DEPTH        (DEPTH),
        .MAX_CHANNELS (MAXCH)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .channels_i  (channels_i),
        .positions_i (positions_i),
        .shift_i     (shift_i),
        .relu_en_i   (relu_en_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o)
    );

    int vectors = 0;
    int miscompares = 0;

    logic signed [31:0] stim [8][DEPTH][LANES];
    int   cfg_nch, cfg_npos, cfg_shift;
    bit   cfg_relu;
    out_t got_q[$];
    int   done_cyc, done_cnt, last_hs_cyc, first_valid_cyc, last_acc_cyc;
    logic busy1, ready1, ovf1, busy_at_done, ovf_end;
    logic stall_rdy [3];
    out_t stall_dat [3];

    // Reference: plain sum over channels, 40-bit wrap, round-half-up shift, clamp, ReLU.
    function automatic logic [16:0] model_q(input int p, input int lane);
        longint s = 0;
        longint r;
        int     ce = (cfg_nch == 0) ? 1 : cfg_nch;
        int     sh = (cfg_shift >= 40) ? 39 : cfg_shift;
        logic   sat = 1'b0;
        for (int c = 0; c < ce; c++) s += longint'(stim[c][p][lane]);
        s = (s <<< 24) >>> 24;
        r = (sh > 0) ? ((s + (longint'(1) <<< (sh - 1))) >>> sh) : s;
        if (r > 32767) begin r = 32767; sat = 1'b1; end
        else if (r < -32768) begin r = -32768; sat = 1'b1; end
`ifdef CONV_ACC_RELU_EN
        if (cfg_relu && r < 0) r = 0;
`endif
        return {sat, r[15:0]};
    endfunction

    function automatic out_t model_beat(input int p);
        out_t e;
        logic [16:0] m;
        for (int l = 0; l < LANES; l++) begin
            m = model_q(p, l);
            e[l] = m[15:0];
        end
        return e;
    endfunction

    task automatic fill_random(input int nch, input int npos, input bit big);
        for (int c = 0; c < ((nch == 0) ? 1 : nch); c++)
            for (int p = 0; p < npos; p++)
                for (int l = 0; l < LANES; l++)
                    stim[c][p][l] = big ? 32'($urandom) : 32'(int'($urandom_range(0, 262143)) - 131072);
    endtask

    // Drives one pass (start pulse then beats) and records handshakes; no checking here.
    task automatic run_pass(input int nch, input int npos, input int sh, input bit relu,
                            input int rmode, input int abort_cyc);
        int ce    = (nch == 0) ? 1 : nch;
        int total = ce * npos;
        int idx   = 0;
        cfg_nch = nch; cfg_npos = npos; cfg_shift = sh; cfg_relu = relu;
        got_q.delete();
        done_cyc = -1; done_cnt = 0; last_hs_cyc = -1; first_valid_cyc = -1; last_acc_cyc = -1;
        @(negedge clk_i);
        start_i = 1'b1; channels_i = CH_W'(nch); positions_i = POS_W'(npos);
        shift_i = SH_W'(sh); relu_en_i = relu; in_valid_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (idx < total) begin
                in_valid_i = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data_i  = {stim[idx / npos][idx % npos][1], stim[idx / npos][idx % npos][0]};
            end else begin
                in_valid_i = 1'b0;
            end
            case (rmode)
                1:       out_ready_i = ($urandom_range(0, 2) != 0);
                2:       out_ready_i = !(cyc >= 2 && cyc <= 4);
                default: out_ready_i = 1'b1;
            endcase
            #1;
            if (cyc == 0) begin busy1 = busy_o; ready1 = in_ready_o; ovf1 = overflow_o; end
            if (rmode == 2 && cyc >= 2 && cyc <= 4) begin
                stall_rdy[cyc-2] = in_ready_o;
                stall_dat[cyc-2] = out_data_o;
            end
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy_o; end
            end
            if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid_o && out_ready_i) begin got_q.push_back(out_data_o); last_hs_cyc = cyc; end
            if (in_valid_i && in_ready_o) begin idx++; last_acc_cyc = cyc; end
            if (cyc == abort_cyc) begin rst_i = 1'b0; #1; break; end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge clk_i);
        end
        ovf_end = overflow_o;
        in_valid_i = 1'b0;
        $display("pass ch=%0d pos=%0d shift=%0d relu=%0b outs=%0d done@%0d ovf=%b",
                 nch, npos, sh, relu, got_q.size(), done_cyc, ovf_end);
    endtask

    task automatic test_reset();
        logic [4:0] obs;
        string      nm [5] = '{"in_ready", "out_valid", "busy", "done", "overflow"};
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        obs = {in_ready_o, out_valid_o, busy_o, done_o, overflow_o};
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (obs[4-i] !== 1'b0) begin miscompares++; $display("FAIL reset_%s: got %b want 0", nm[i], obs[4-i]); end
        end
        vectors++; if (out_data_o !== '0) begin miscompares++; $display("FAIL reset_out_data: got %h want 0", out_data_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_passthrough();
        stim[0][0][0] = 32'h0000_1234; stim[0][0][1] = 32'hFFFF_FFFE;
        run_pass(1, 1, 0, 1'b0, 0, -1);
        vectors++; if (busy1 !== 1'b1) begin miscompares++; $display("FAIL pt_busy_t1: got %b want 1", busy1); end
        vectors++; if (ready1 !== 1'b1) begin miscompares++; $display("FAIL pt_ready_t1: got %b want 1", ready1); end
        vectors++; if (got_q.size() != 1) begin miscompares++; $display("FAIL pt_count: got %0d want 1", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== {16'hFFFE, 16'h1234}) begin miscompares++; $display("FAIL pt_data: got %h want fffe1234", got_q[0]); end
        end
        vectors++; if (first_valid_cyc != last_acc_cyc + 1) begin miscompares++; $display("FAIL pt_latency: valid@%0d want %0d", first_valid_cyc, last_acc_cyc + 1); end
        vectors++; if (done_cyc != last_hs_cyc + 1 || done_cyc < 0) begin miscompares++; $display("FAIL pt_done: done@%0d want %0d", done_cyc, last_hs_cyc + 1); end
        vectors++; if (busy_at_done !== 1'b0) begin miscompares++; $display("FAIL pt_busy_done: got %b want 0", busy_at_done); end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL pt_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_multichannel();
        int   v0 [3] = '{100, 200, 300};
        out_t exp0 = {16'hFF6A, 16'd150};
        out_t exp1 = {16'hFFFD, 16'd3};
        for (int c = 0; c < 3; c++) begin
            stim[c][0][0] = v0[c]; stim[c][0][1] = -v0[c];
            stim[c][1][0] = 4;     stim[c][1][1] = -4;
        end
        run_pass(3, 2, 2, 1'b0, 0, -1);
        vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL mc_count: got %0d want 2", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== exp0) begin miscompares++; $display("FAIL mc_pos0: got %h want %h", got_q[0], exp0); end
            vectors++; if (got_q[1] !== exp1) begin miscompares++; $display("FAIL mc_pos1: got %h want %h", got_q[1], exp1); end
        end
        vectors++; if (done_cnt != 1) begin miscompares++; $display("FAIL mc_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_rounding();
        int   l0 [3] = '{6, -6, 5};
        int   l1 [3] = '{7, -7, -5};
        out_t exp [3] = '{{16'd2, 16'd2}, {16'hFFFE, 16'hFFFF}, {16'hFFFF, 16'd1}};
        for (int p = 0; p < 3; p++) begin stim[0][p][0] = l0[p]; stim[0][p][1] = l1[p]; end
        run_pass(1, 3, 2, 1'b0, 0, -1);
        for (int p = 0; p < 3; p++) begin
            vectors++;
            if (p >= got_q.size() || got_q[p] !== exp[p]) begin
                miscompares++; $display("FAIL round_pos%0d: got %h want %h", p, (p < got_q.size()) ? got_q[p] : out_t'('x), exp[p]);
            end
        end
        vectors++; if (ovf_end !== 1'b0) begin miscompares++; $display("FAIL round_ovf: got %b want 0", ovf_end); end
    endtask

    task automatic test_saturation();
        out_t exp0 = {16'h8000, 16'h7FFF};
        out_t exp1 = {16'h8000, 16'h7FFF};
        stim[0][0][0] = 32'h0001_0000; stim[0][0][1] = 32'hFFFF_0000;
        stim[0][1][0] = 32'h0000_7FFF; stim[0][1][1] = 32'hFFFF_8000;
        run_pass(1, 2, 0, 1'b0, 0, -1);
        vectors++; if (got_q.size() != 2) begin miscompares++; $display("FAIL sat_count: got %0d want 2", got_q.size()); end
        else begin
            vectors++; if (got_q[0] !== exp0) begin miscompares++; $display("FAIL sat_clamp: got %h want %h", got_q[0], exp0); end
            vectors++; if (got_q[1] !== exp1) begin miscompares++; $display("FAIL sat_limits: got %h want %h", got_q[1], exp1); end
        end
        vectors++; if (ovf_end !== 1'b1) begin miscompares++; $display("FAIL sat_ovf: got %b want 1", ovf_end); end
    endtask

    task automatic test_relu();
        out_t exp;
`ifdef CONV_ACC_RELU_EN
        exp = {16'd7, 16'h0000};
`else
        exp = {16'd7, 16'hFFFB};
`endif
        stim[0][0][0] = -5; stim[0][0][1] = 7;
        run_pass(1, 1, 0, 1'b1, 0, -1);
        vectors++; if (ovf1 !== 1'b0) begin miscompares++; $display("FAIL relu_ovf_cleared: got %b want 0", ovf1); end
        vectors++; if (got_q.size() != 1 || got_q[0] !== exp) begin miscompares++; $display("FAIL relu_data: got %0d beats first %h want %h", got_q.size(), (got_q.size() > 0) ? got_q[0] : out_t'('x), exp); end
        vectors++; if (ovf_end !== 1'b0) begin miscompares++; $display("FAIL relu_ovf: got %b want 0", ovf_end); end
    endtask

    task automatic test_zero_positions();
        run_pass(2, 0, 0, 1'b0, 0, -1);
        vectors++; if (done_cnt != 1 || done_cyc != 0) begin miscompares++; $display("FAIL zp_done: count %0d at %0d want 1 at 0", done_cnt, done_cyc); end
        vectors++; if (busy1 !== 1'b0) begin miscompares++; $display("FAIL zp_busy: got %b want 0", busy1); end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL zp_outputs: got %0d want 0", got_q.size()); end
    endtask

    task automatic test_backpressure();
        out_t hold;
        fill_random(1, 6, 1'b0);
        run_pass(1, 6, 1, 1'b0, 2, -1);
        hold = model_beat(1);
        for (int i = 0; i < 3; i++) begin
            vectors++; if (stall_rdy[i] !== 1'b0) begin miscompares++; $display("FAIL bp_ready_%0d: got %b want 0", i, stall_rdy[i]); end
            vectors++; if (stall_dat[i] !== hold) begin miscompares++; $display("FAIL bp_hold_%0d: got %h want %h", i, stall_dat[i], hold); end
        end
        vectors++; if (got_q.size() != 6) begin miscompares++; $display("FAIL bp_count: got %0d want 6", got_q.size()); end
        for (int p = 0; p < got_q.size() && p < 6; p++) begin
            vectors++; if (got_q[p] !== model_beat(p)) begin miscompares++; $display("FAIL bp_pos%0d: got %h want %h", p, got_q[p], model_beat(p)); end
        end
    endtask

    task automatic test_reset_mid_pass();
        fill_random(3, 4, 1'b0);
        run_pass(3, 4, 0, 1'b0, 0, 3);
        vectors++; if ({in_ready_o, out_valid_o, busy_o, done_o, overflow_o} !== 5'b0) begin
            miscompares++; $display("FAIL abort_flags: got %b want 00000", {in_ready_o, out_valid_o, busy_o, done_o, overflow_o});
        end
        vectors++; if (out_data_o !== '0) begin miscompares++; $display("FAIL abort_data: got %h want 0", out_data_o); end
        vectors++; if (done_cnt != 0) begin miscompares++; $display("FAIL abort_done: got %0d pulses want 0", done_cnt); end
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_random(input int passes);
        int          nch, npos, sh;
        bit          relu;
        logic        ovf_exp;
        logic [16:0] m;
        for (int k = 0; k < passes; k++) begin
            nch  = $urandom_range(0, 4);
            npos = $urandom_range(1, DEPTH);
            sh   = ($urandom_range(0, 3) == 0) ? 63 : $urandom_range(0, 20);
            relu = 1'($urandom_range(0, 1));
            fill_random(nch, npos, 1'($urandom_range(0, 1)));
            run_pass(nch, npos, sh, relu, 1, -1);
            ovf_exp = 1'b0;
            for (int p = 0; p < npos; p++)
                for (int l = 0; l < LANES; l++) begin
                    m = model_q(p, l);
                    ovf_exp |= m[16];
                end
            vectors++; if (got_q.size() != npos) begin miscompares++; $display("FAIL rnd%0d_count: got %0d want %0d", k, got_q.size(), npos); end
            for (int p = 0; p < got_q.size() && p < npos; p++) begin
                vectors++; if (got_q[p] !== model_beat(p)) begin miscompares++; $display("FAIL rnd%0d_pos%0d: got %h want %h", k, p, got_q[p], model_beat(p)); end
            end
            vectors++; if (ovf_end !== ovf_exp) begin miscompares++; $display("FAIL rnd%0d_ovf: got %b want %b", k, ovf_end, ovf_exp); end
            vectors++; if (done_cnt != 1 || done_cyc != last_hs_cyc + 1) begin miscompares++; $display("FAIL rnd%0d_done: count %0d at %0d want 1 at %0d", k, done_cnt, done_cyc, last_hs_cyc + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_multichannel();
        test_rounding();
        test_saturation();
        test_relu();
        test_zero_positions();
        test_backpressure();
        test_reset_mid_pass();
        test_random(2);
        test_random(8);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/conv_accumulator.md
# conv_accumulator

Multi-lane output stage for the convolution layer. It accumulates raw 2N-bit convolver results across input channels in an internal partial-sum buffer. On the final channel pass it requantises each sum to N bits with a rounding arithmetic shift, saturation and optional ReLU. Results leave through a valid/ready handshake toward the result BRAM writer, replacing the unshifted, unsaturated sum path in the current layer.

## Interface
- Lanes, 4, parallel engine lanes handled per beat
- N, 16, output width; input width is 2N
- Depth, 1024, maximum output positions per feature map
- MaxChannels, 256, maximum input channels accumulated
- AccW, 2N+$clog2(MaxChannels), accumulator width (derived, not overridable)

Ports:
- clk_i  in  1  clock; the only clock
- rst_i  in  1  asynchronous reset, active low
- start_i  in  1  begin a layer pass; latches config
- channels_i  in  $clog2(MaxChannels+1)  input channels to accumulate
- positions_i  in  $clog2(Depth+1)  output positions per map
- shift_i  in  $clog2(AccW)  right-shift amount
- relu_en_i  in  1  enable ReLU (effective only with the macro)
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  input beat accepted when valid&&ready
- in_data_i  in  Lanes x 2N  signed convolver results
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  Lanes x N  signed requantised results
- busy_o  out  1  pass in progress
- done_o  out  1  one-cycle pulse at pass end
- overflow_o  out  1  sticky saturation flag

## Operation
- FSM states: IDLE, ACCUM, FINAL, FLUSH.
- IDLE: start_i latches channels_i, positions_i, shift_i and relu_en_i. It clears pos, ch and overflow_o.
  - channels_i=0 is treated as 1.
  - positions_i=0 skips straight to a done_o pulse and stays in IDLE.
  - Next state is ACCUM, or FINAL if the effective channel count is 1.
- start_i outside IDLE is ignored.
- ACCUM, per accepted beat, per lane:
  - ch==0: mem[pos] = sext(in).
  - otherwise: mem[pos] = mem[pos] + sext(in), wrapping in AccW.
  - pos increments. At pos==positions-1 it wraps to 0 and ch increments.
  - When ch reaches channels-1, state moves to FINAL.
- FINAL: sum = mem[pos] + sext(in), or sext(in) alone if channels==1. The sum is requantised into the output register; out_valid_o is set and pos increments. After the last position, state moves to FLUSH.
- FLUSH: wait until the output register drains, then pulse done_o and go to IDLE.
- Requantise, per lane:
  - r = (sum + (shift>0 ? 1<<(shift-1) : 0)) >>> shift, i.e. round half toward +inf.
  - Saturate r to [-2^(N-1), 2^(N-1)-1]; clamping sets overflow_o.
  - ReLU is applied after saturation.
  - shift_i >= AccW is clamped to AccW-1.
- Partial-sum memory: Lanes x Depth x AccW, asynchronous read, synchronous write. Contents are not reset.
- in_ready_o:
  - IDLE and FLUSH: 0.
  - ACCUM: 1.
  - FINAL: !out_valid_o || out_ready_i (single-entry skid).

## Timing
- Reset values: in_ready_o=0, out_valid_o=0, out_data_o=0, busy_o=0, done_o=0, overflow_o=0, state IDLE.
- Reset mid-pass aborts immediately to IDLE without a done_o pulse.
- start_i at cycle t: busy_o=1 and in_ready_o=1 at t+1.
- FINAL beat accepted at t: out_valid_o=1 with its data at t+1.
- out_data_o is stable while out_valid_o && !out_ready_i.
- If an output is consumed and a new input accepted in the same cycle, the output register reloads with no bubble. Full throughput is 1 beat/cycle.
- done_o pulses the cycle after the last output handshake. busy_o drops in the same cycle.
- overflow_o holds until the next start_i.

## Configuration
- CONV_ACC_RELU_EN defined: ReLU hardware is present, and negative results become 0 when the latched relu_en_i is 1.
- Undefined: no ReLU logic is built, relu_en_i is ignored and signed results pass through.

## Structure
- conv_acc_pkg holds:
  - the state enum conv_acc_state_e;
  - the AccW derivation function;
  - saturation limit constants as functions of N.
- Sub-module conv_requant is one lane of combinational round/shift/saturate/ReLU. It is instantiated Lanes times and outputs a per-lane saturation flag.

## Test plan
- Lanes=2, N=16, channels=1, positions=1, shift=0, in={0x00001234, 0xFFFFFFFE} -> out {0x1234, 0xFFFE} one cycle after accept; done_o follows the output handshake.
- channels=3, positions=2, shift=2, pos0 beats 100,200,300 and pos1 beats 4,4,4 -> outputs 150 then 3, in that order.
- Rounding, shift=2: 6 -> 2, -6 -> -1, 5 -> 1.
- Saturation, shift=0: 0x00010000 -> 0x7FFF and overflow_o=1; 0xFFFF0000 -> 0x8000; overflow_o clears on next start_i.
- ReLU: -5 with relu_en_i=1 -> 0x0000 with CONV_ACC_RELU_EN, 0xFFFB without it.
- Backpressure and reset:
  - out_ready_i low for 3 cycles in FINAL -> in_ready_o=0 and out_data_o held.
  - rst_i low mid-ACCUM -> all outputs at reset values, no done_o.
  - A new start_i then completes correctly.
